// File: rtl/wb_slave_mem_responder_if.sv
// Wishbone B4 classic-cycle bus bundle between a master agent and the memory responder.
// A transfer is offered while cyc_i & stb_i are high and completes on the cycle ack_o or err_o is high.
interface wb_slave_mem_responder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   adr_i;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic [DATA_WIDTH/8-1:0] sel_i;
    logic                    we_i;
    logic                    cyc_i;
    logic                    stb_i;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic                    ack_o;
    logic                    err_o;

    modport slave (
        input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        output dat_o, ack_o, err_o
    );

    modport master (
        output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        input  dat_o, ack_o, err_o
    );
endinterface

// File: rtl/wb_slave_mem_responder.sv
// Wishbone classic slave backed by a word-addressed RAM with programmable wait states.
// Optional WB_SLV_ADDR_ERR_EN: addresses beyond the memory terminate with err_o instead of aliasing.
module wb_slave_mem_responder #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 64,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_slave_mem_responder_if.slave bus,
    output logic [CNT_WIDTH-1:0]  xfer_cnt,
    output logic [1:0]            fsm_state
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int OFS       = $clog2(SEL_WIDTH);
    localparam int IDX_WIDTH = $clog2(MEM_DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]            state;
    logic [3:0]            wait_cnt;
    logic [IDX_WIDTH-1:0]  lat_idx;
    logic [DATA_WIDTH-1:0] lat_dat;
    logic [SEL_WIDTH-1:0]  lat_sel;
    logic                  lat_we;
    logic                  lat_err;
    logic                  ack_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  req;
    logic                  go_resp;
    logic [IDX_WIDTH-1:0]  in_idx;
    logic                  in_err;
    logic [IDX_WIDTH-1:0]  cur_idx;
    logic [DATA_WIDTH-1:0] cur_dat;
    logic [SEL_WIDTH-1:0]  cur_sel;
    logic                  cur_we;
    logic                  cur_err;
    logic                  unused_adr;

    assign req    = bus.cyc_i & bus.stb_i;
    assign in_idx = bus.adr_i[OFS +: IDX_WIDTH];
    assign unused_adr = ^bus.adr_i;

`ifdef WB_SLV_ADDR_ERR_EN
    assign in_err = |(bus.adr_i >> (OFS + IDX_WIDTH));
`else
    assign in_err = 1'b0;
`endif

    // With zero wait states the response is decided straight from the bus, otherwise from the latch.
    assign cur_idx = (state == IDLE) ? in_idx     : lat_idx;
    assign cur_dat = (state == IDLE) ? bus.dat_i  : lat_dat;
    assign cur_sel = (state == IDLE) ? bus.sel_i  : lat_sel;
    assign cur_we  = (state == IDLE) ? bus.we_i   : lat_we;
    assign cur_err = (state == IDLE) ? in_err     : lat_err;

    always_comb begin
        go_resp = 1'b0;
        if (state == IDLE) begin
            go_resp = req && (WAIT_STATES == 0);
        end else if (state == WAIT) begin
            go_resp = req && (wait_cnt == 4'd0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            lat_idx  <= '0;
            lat_dat  <= '0;
            lat_sel  <= '0;
            lat_we   <= 1'b0;
            lat_err  <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= '0;
            xfer_cnt <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rd_q  <= '0;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_idx  <= in_idx;
                        lat_dat  <= bus.dat_i;
                        lat_sel  <= bus.sel_i;
                        lat_we   <= bus.we_i;
                        lat_err  <= in_err;
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    // A master that lets go of cyc/stb while we stall has abandoned the transfer.
                    if (!req) begin
                        state <= IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (go_resp) begin
                if (cur_err) begin
                    err_q <= 1'b1;
                end else begin
                    ack_q    <= 1'b1;
                    xfer_cnt <= xfer_cnt + 1'b1;
                    if (!cur_we) begin
                        rd_q <= mem[cur_idx];
                    end
                end
            end
        end
    end

    // Contents survive reset; a reset during WAIT leaves the FSM in IDLE so no commit happens.
    always_ff @(posedge clk) begin
        if (go_resp && cur_we && !cur_err) begin
            for (int b = 0; b < SEL_WIDTH; b++) begin
                if (cur_sel[b]) begin
                    mem[cur_idx][b*8 +: 8] <= cur_dat[b*8 +: 8];
                end
            end
        end
    end

    assign bus.ack_o = ack_q & bus.cyc_i;
    assign bus.err_o = err_q & bus.cyc_i;
    assign bus.dat_o = rd_q;
    assign fsm_state = state;

endmodule
